// File: rtl/dm_burst_seq.sv
// DM burst sequencer: drives per-cycle DM data/tristate nibbles for BL8 write bursts
// and runs a set/load/ack handshake that programs the DM output delay element.
module dm_burst_seq #(
    parameter int   DLY_LD_WAIT = 2,
    parameter logic DM_IDLE     = 1'b0
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       wr_start,
    input  logic [7:0] dm_mask,
    output logic       ready,
    output logic [3:0] din,
    output logic [3:0] tin,
    input  logic       dly_req,
    input  logic [7:0] dly_val,
    output logic       dly_ack,
    output logic [7:0] dly_data,
    output logic       set_odelay,
    output logic       ld_odelay,
    output logic       err_overrun
);

    typedef enum logic [2:0] {IDLE, PRE, D0, D1, POST} burst_t;
    typedef enum logic [2:0] {D_IDLE, D_SET, D_WAIT, D_LD, D_ACK} dly_t;

    localparam logic [3:0] WAIT_INIT = (DLY_LD_WAIT > 1) ? 4'(DLY_LD_WAIT - 2) : 4'd0;
    localparam logic [3:0] DIN_IDLE  = {4{DM_IDLE}};

    burst_t     state, state_next;
    dly_t       dstate, dstate_next;
    logic [7:0] mask_q, mask_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] din_next, tin_next;
    logic       wr_acc, dly_acc;

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = (dstate == D_IDLE);
            D1:      ready = 1'b1;
            POST:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign wr_acc  = wr_start && ready;
    assign dly_acc = (dstate == D_IDLE) && dly_req && (state == IDLE) && !wr_start;

    // The upper nibble of an in-flight burst is already registered into din when a
    // new burst is accepted in D1, so the next D0 beat comes straight from dm_mask.
    assign mask_next = wr_acc ? dm_mask : mask_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_acc) state_next = PRE;
            PRE:     state_next = D0;
            D0:      state_next = D1;
            D1:      state_next = wr_start ? D0 : POST;
            POST:    state_next = wr_start ? D0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tin_next = 4'h0;
        din_next = DIN_IDLE;
        case (state_next)
            IDLE:    tin_next = 4'hF;
            D0:      din_next = mask_next[3:0];
            D1:      din_next = mask_next[7:4];
            default: din_next = DIN_IDLE;
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= 8'h00;
            tin         <= 4'hF;
            din         <= DIN_IDLE;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            mask_q      <= mask_next;
            tin         <= tin_next;
            din         <= din_next;
            err_overrun <= err_overrun | (wr_start & ~ready);
        end
    end

    always_comb begin
        dstate_next = dstate;
        cnt_next    = cnt;
        case (dstate)
            D_IDLE: if (dly_acc) dstate_next = D_SET;
            D_SET: begin
                dstate_next = (DLY_LD_WAIT > 1) ? D_WAIT : D_LD;
                cnt_next    = WAIT_INIT;
            end
            D_WAIT: begin
                if (cnt == 4'd0) dstate_next = D_LD;
                else             cnt_next    = cnt - 4'd1;
            end
            D_LD:    dstate_next = D_ACK;
            D_ACK:   dstate_next = D_IDLE;
            default: dstate_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            dstate     <= D_IDLE;
            cnt        <= 4'd0;
            dly_data   <= 8'h00;
            set_odelay <= 1'b0;
            ld_odelay  <= 1'b0;
            dly_ack    <= 1'b0;
        end else begin
            dstate     <= dstate_next;
            cnt        <= cnt_next;
            if (dly_acc) dly_data <= dly_val;
            set_odelay <= (dstate_next == D_SET);
            ld_odelay  <= (dstate_next == D_LD);
            dly_ack    <= (dstate_next == D_ACK);
        end
    end

endmodule
